// File: rtl/axil_master_fsm.sv
// Single-outstanding AXI4-Lite master bridging a valid/ready core request port.
// Optional per-transaction abort timer is enabled with `define AXIL_MASTER_TIMEOUT_EN.
module axil_master_fsm #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,  // 32 or 64
  parameter int TIMEOUT_CYCLES = 255  // 1..65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]              axi_awprot,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]              axi_arprot,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    timeout_hit;
  logic                    unused_resp;

  assign aw_hs       = axi_awvalid & axi_awready;
  assign w_hs        = axi_wvalid & axi_wready;
  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = strb_q;
  assign axi_awprot  = 3'b000;
  assign axi_arprot  = 3'b000;
  // Only the error bit of the responses matters; OKAY vs EXOKAY is irrelevant here.
  assign unused_resp = axi_bresp[0] ^ axi_rresp[0];

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [15:0] timeout_cnt;

  always_ff @(posedge clk) begin
    if (rst)                timeout_cnt <= '0;
    else if (state == IDLE) timeout_cnt <= '0;
    else if (state != DONE) timeout_cnt <= timeout_cnt + 16'd1;
  end

  // Fires in the last allowed busy cycle so the abort lands after exactly TIMEOUT_CYCLES.
  assign timeout_hit = (state != IDLE) && (state != DONE) &&
                       (timeout_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    if (rst) begin
      state       <= IDLE;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      // NOTE: the payload copies are reset too so every output reads 0 straight after reset.
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            strb_q  <= we_i;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (|we_i) begin
              state       <= WRITE;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
            end else begin
              state       <= READ;
              axi_arvalid <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (aw_hs) begin
            axi_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state      <= WRESP;
            axi_bready <= 1'b1;
          end else if (timeout_hit) begin
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            state       <= DONE;
            ready_o     <= 1'b1;
            err_o       <= 1'b1;
            rdata_o     <= '0;
          end
        end
        WRESP: begin
          if (axi_bvalid || timeout_hit) begin
            axi_bready <= 1'b0;
            state      <= DONE;
            ready_o    <= 1'b1;
            err_o      <= axi_bvalid ? axi_bresp[1] : 1'b1;
            rdata_o    <= '0;
          end
        end
        READ: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RRESP;
          end else if (timeout_hit) begin
            axi_arvalid <= 1'b0;
            state       <= DONE;
            ready_o     <= 1'b1;
            err_o       <= 1'b1;
            rdata_o     <= '0;
          end
        end
        RRESP: begin
          if (axi_rvalid || timeout_hit) begin
            axi_rready <= 1'b0;
            state      <= DONE;
            ready_o    <= 1'b1;
            err_o      <= axi_rvalid ? axi_rresp[1] : 1'b1;
            rdata_o    <= axi_rvalid ? axi_rdata : '0;
          end
        end
        DONE: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
